// File: rtl/common_cells_pkg.sv
// rtl/common_cells_pkg.sv - shared FSM encoding and helpers for the DMA/APB port arbiter
package common_cells_pkg;

    localparam int APB_ARB_FSM_WIDTH = 2;

    typedef enum logic [APB_ARB_FSM_WIDTH-1:0] {
        FSM_APB_ARB_IDLE    = 2'b00,
        FSM_APB_ARB_GRANT   = 2'b01,
        FSM_APB_ARB_RELEASE = 2'b10
    } apb_arb_state_e;

    // Beat counter add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] beat_sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// rtl/dma_rr_picker.sv - combinational round-robin search: first requester at or after ptr, with wrap
module dma_rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    logic w_found;

    always_comb begin
        int j;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!w_found && i_req[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = PW'(j);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/dma_apb_port_arbiter.sv
// rtl/dma_apb_port_arbiter.sv - round-robin, transfer-locked sharing of one DMA<->APB FIFO port
// Optional idle-beat watchdog: define DMA_APB_ARB_WDOG_EN.
module dma_apb_port_arbiter
    import common_cells_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int APB_SVL        = 4,
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 16,
    parameter int WDOG_CYCLES    = 1024,
    parameter int PSEL_W         = (APB_SVL > 1) ? $clog2(APB_SVL) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [NUM_CH-1:0]                 i_ch_req,
    input  logic [NUM_CH-1:0]                 i_ch_done,
    input  logic [NUM_CH-1:0]                 i_ch_wvalid,
    input  logic [NUM_CH-1:0]                 i_ch_rready,
    input  logic [NUM_CH-1:0]                 i_ch_pwrite,
    input  logic [NUM_CH*PSEL_W-1:0]          i_ch_psel,
    input  logic [NUM_CH*APB_DATA_WIDTH-1:0]  i_ch_pdata,
    input  logic [NUM_CH*APB_ADDR_WIDTH-1:0]  i_ch_paddr,
    output logic [NUM_CH-1:0]                 o_ch_gnt,
    output logic [NUM_CH-1:0]                 o_ch_full,
    output logic [NUM_CH-1:0]                 o_ch_empty,
    output logic [APB_DATA_WIDTH-1:0]         o_ch_pdata,
    output logic [NUM_CH-1:0]                 o_ch_abort,
    input  logic                              i_dma2apb_full,
    input  logic                              i_apb2dma_empty,
    input  logic [APB_DATA_WIDTH-1:0]         i_apb_pdata,
    output logic                              o_dma2apb_wvalid,
    output logic                              o_apb2dma_rready,
    output logic                              o_apb_pwrite,
    output logic [PSEL_W-1:0]                 o_apb_psel,
    output logic [APB_DATA_WIDTH-1:0]         o_apb_pdata,
    output logic [APB_ADDR_WIDTH-1:0]         o_apb_paddr,
    output logic                              o_busy,
    output logic [15:0]                       o_beat_cnt
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("NUM_CH must be within 2..8");
    end
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 2");
    end

    apb_arb_state_e      r_state;
    logic [NUM_CH-1:0]   r_gnt;
    logic [CH_W-1:0]     r_winner;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [15:0]         r_beat_cnt;

    logic [NUM_CH-1:0]   w_pick_oh;
    logic [CH_W-1:0]     w_pick_idx;
    logic                w_pick_valid;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_inc;
    logic                w_end_xfer;

    dma_rr_picker #(
        .N  (NUM_CH),
        .PW (CH_W)
    ) u_picker (
        .i_req   (i_ch_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Beat gating is purely combinational so granted beats see no extra latency.
    assign w_push = (|(i_ch_wvalid & r_gnt)) && !i_dma2apb_full;
    assign w_pop  = (|(i_ch_rready & r_gnt)) && !i_apb2dma_empty;
    assign w_inc  = {1'b0, w_push} + {1'b0, w_pop};

    assign o_dma2apb_wvalid = w_push;
    assign o_apb2dma_rready = w_pop;
    assign o_ch_full        = {NUM_CH{i_dma2apb_full}} | ~r_gnt;
    assign o_ch_empty       = {NUM_CH{i_apb2dma_empty}} | ~r_gnt;
    assign o_ch_pdata       = i_apb_pdata;
    assign o_ch_gnt         = r_gnt;
    assign o_busy           = (r_state != FSM_APB_ARB_IDLE);
    assign o_beat_cnt       = r_beat_cnt;

    assign w_end_xfer = i_ch_done[r_winner] || !i_ch_req[r_winner];

    // AND-OR mux: with no grant every downstream field collapses to zero.
    always_comb begin
        o_apb_pwrite = 1'b0;
        o_apb_psel   = '0;
        o_apb_pdata  = '0;
        o_apb_paddr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_gnt[i]) begin
                o_apb_pwrite = o_apb_pwrite | i_ch_pwrite[i];
                o_apb_psel   = o_apb_psel   | i_ch_psel[i*PSEL_W +: PSEL_W];
                o_apb_pdata  = o_apb_pdata  | i_ch_pdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                o_apb_paddr  = o_apb_paddr  | i_ch_paddr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            end
        end
    end

`ifdef DMA_APB_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES);

    logic [WDOG_W-1:0]   r_wdog;
    logic [NUM_CH-1:0]   r_abort;

    assign o_ch_abort = r_abort;
`else
    assign o_ch_abort = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FSM_APB_ARB_IDLE;
            r_gnt      <= '0;
            r_winner   <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
`ifdef DMA_APB_ARB_WDOG_EN
            r_wdog     <= '0;
            r_abort    <= '0;
`endif
        end else begin
`ifdef DMA_APB_ARB_WDOG_EN
            r_abort <= '0;
`endif
            case (r_state)
                FSM_APB_ARB_IDLE: begin
                    if (enable && w_pick_valid) begin
                        r_state    <= FSM_APB_ARB_GRANT;
                        r_gnt      <= w_pick_oh;
                        r_winner   <= w_pick_idx;
                        r_beat_cnt <= '0;
`ifdef DMA_APB_ARB_WDOG_EN
                        r_wdog     <= '0;
`endif
                    end
                end

                FSM_APB_ARB_GRANT: begin
                    r_beat_cnt <= beat_sat_add(r_beat_cnt, w_inc);
                    if (w_end_xfer) begin
                        r_state <= FSM_APB_ARB_RELEASE;
                        r_gnt   <= '0;
                    end
`ifdef DMA_APB_ARB_WDOG_EN
                    else if (w_inc != 2'd0) begin
                        r_wdog <= '0;
                    end else if (r_wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
                        r_abort[r_winner] <= 1'b1;
                        r_state           <= FSM_APB_ARB_RELEASE;
                        r_gnt             <= '0;
                        r_wdog            <= '0;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
`endif
                end

                FSM_APB_ARB_RELEASE: begin
                    r_state  <= FSM_APB_ARB_IDLE;
                    r_gnt    <= '0;
                    r_rr_ptr <= (r_winner == CH_W'(NUM_CH - 1)) ? '0 : r_winner + CH_W'(1);
                end

                default: begin
                    r_state <= FSM_APB_ARB_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_apb_port_arbiter.sv
// tb/tb_dma_apb_port_arbiter.sv - directed self-checking bench for dma_apb_port_arbiter
module tb_dma_apb_port_arbiter;

    localparam int NCH = 4;
    localparam int PSW = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [NCH-1:0]     i_ch_req, i_ch_done, i_ch_wvalid, i_ch_rready, i_ch_pwrite;
    logic [NCH*PSW-1:0] i_ch_psel;
    logic [NCH*DW-1:0]  i_ch_pdata;
    logic [NCH*AW-1:0]  i_ch_paddr;
    logic [NCH-1:0]     o_ch_gnt, o_ch_full, o_ch_empty, o_ch_abort;
    logic [DW-1:0]      o_ch_pdata;
    logic               i_dma2apb_full, i_apb2dma_empty;
    logic [DW-1:0]      i_apb_pdata;
    logic               o_dma2apb_wvalid, o_apb2dma_rready, o_apb_pwrite, o_busy;
    logic [PSW-1:0]     o_apb_psel;
    logic [DW-1:0]      o_apb_pdata;
    logic [AW-1:0]      o_apb_paddr;
    logic [15:0]        o_beat_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_apb_port_arbiter #(
        .NUM_CH(NCH), .APB_SVL(4), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .WDOG_CYCLES(1024)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .i_ch_req(i_ch_req), .i_ch_done(i_ch_done), .i_ch_wvalid(i_ch_wvalid),
        .i_ch_rready(i_ch_rready), .i_ch_pwrite(i_ch_pwrite), .i_ch_psel(i_ch_psel),
        .i_ch_pdata(i_ch_pdata), .i_ch_paddr(i_ch_paddr),
        .o_ch_gnt(o_ch_gnt), .o_ch_full(o_ch_full), .o_ch_empty(o_ch_empty),
        .o_ch_pdata(o_ch_pdata), .o_ch_abort(o_ch_abort),
        .i_dma2apb_full(i_dma2apb_full), .i_apb2dma_empty(i_apb2dma_empty),
        .i_apb_pdata(i_apb_pdata),
        .o_dma2apb_wvalid(o_dma2apb_wvalid), .o_apb2dma_rready(o_apb2dma_rready),
        .o_apb_pwrite(o_apb_pwrite), .o_apb_psel(o_apb_psel), .o_apb_pdata(o_apb_pdata),
        .o_apb_paddr(o_apb_paddr), .o_busy(o_busy), .o_beat_cnt(o_beat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int zeros;
        logic [NCH-1:0] exp_gnt;

        reset = 1'b1; enable = 1'b1;
        i_ch_req = '0; i_ch_done = '0; i_ch_wvalid = '0; i_ch_rready = '0; i_ch_pwrite = '0;
        i_ch_psel = '0; i_ch_pdata = '0; i_ch_paddr = '0;
        i_dma2apb_full = 1'b0; i_apb2dma_empty = 1'b1; i_apb_pdata = '0;
        step(); step();
        chk("rst_gnt",   32'(o_ch_gnt),   32'h0);
        chk("rst_full",  32'(o_ch_full),  32'hF);
        chk("rst_empty", 32'(o_ch_empty), 32'hF);
        chk("rst_busy",  32'(o_busy),     32'h0);
        chk("rst_beat",  32'(o_beat_cnt), 32'h0);
        chk("rst_wv",    32'(o_dma2apb_wvalid), 32'h0);
        chk("rst_abort", 32'(o_ch_abort), 32'h0);
        reset = 1'b0;

        // Fairness: all four requesting, each grant ended by done.
        i_ch_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            zeros = 0;
            while (o_ch_gnt == '0 && zeros < 10) begin
                zeros++;
                step();
            end
            exp_gnt = NCH'(1) << (k % NCH);
            chk($sformatf("fair_gnt%0d", k), 32'(o_ch_gnt), 32'(exp_gnt));
            if (k > 0) chk($sformatf("fair_gap%0d", k), 32'(zeros), 32'd2);
            i_ch_done = o_ch_gnt;
            step();
            i_ch_done = '0;
        end
        i_ch_req = '0;
        step(); step();

        // Single request on ch1 (ptr now 1).
        i_ch_req = 4'b0010;
        step();
        chk("single_gnt",  32'(o_ch_gnt),  32'h2);
        chk("single_full", 32'(o_ch_full), 32'hD);
        i_ch_wvalid = 4'b0010;
        #1;
        chk("single_wv", 32'(o_dma2apb_wvalid), 32'h1);
        repeat (8) step();
        i_ch_wvalid = '0;
        chk("single_beat8", 32'(o_beat_cnt), 32'd8);
        i_ch_done = 4'b0010;
        step();
        i_ch_done = '0;
        chk("single_rel_gnt",  32'(o_ch_gnt), 32'h0);
        chk("single_rel_busy", 32'(o_busy),   32'h1);
        i_ch_req = '0;
        step();
        chk("single_idle", 32'(o_busy), 32'h0);

        // Isolation: ch2 granted, ch0 tries to push.
        i_ch_paddr[0*AW +: AW] = 16'h1111; i_ch_pdata[0*DW +: DW] = 16'h0C0C; i_ch_psel[0*PSW +: PSW] = 2'd1;
        i_ch_paddr[2*AW +: AW] = 16'hA2A2; i_ch_pdata[2*DW +: DW] = 16'h2C2C; i_ch_psel[2*PSW +: PSW] = 2'd2;
        i_ch_pwrite = 4'b0100;
        i_ch_req = 4'b0100;
        step();
        chk("iso_gnt", 32'(o_ch_gnt), 32'h4);
        i_ch_wvalid = 4'b0001;
        #1;
        chk("iso_wv_blocked", 32'(o_dma2apb_wvalid), 32'h0);
        chk("iso_full",   32'(o_ch_full),   32'hB);
        chk("iso_paddr",  32'(o_apb_paddr), 32'hA2A2);
        chk("iso_pdata",  32'(o_apb_pdata), 32'h2C2C);
        chk("iso_psel",   32'(o_apb_psel),  32'h2);
        chk("iso_pwrite", 32'(o_apb_pwrite), 32'h1);
        i_apb2dma_empty = 1'b0; i_apb_pdata = 16'h5A5A;
        i_ch_wvalid = 4'b0100; i_ch_rready = 4'b0100;
        #1;
        chk("iso_wv",    32'(o_dma2apb_wvalid), 32'h1);
        chk("iso_rr",    32'(o_apb2dma_rready), 32'h1);
        chk("iso_empty", 32'(o_ch_empty),       32'hB);
        chk("iso_rdata", 32'(o_ch_pdata),       32'h5A5A);
        step();
        chk("dual_beat2", 32'(o_beat_cnt), 32'd2);

        // Backpressure on the write FIFO.
        i_ch_rready = '0; i_apb2dma_empty = 1'b1; i_dma2apb_full = 1'b1;
        #1;
        chk("bp_wv",   32'(o_dma2apb_wvalid), 32'h0);
        chk("bp_full", 32'(o_ch_full),        32'hF);
        repeat (5) step();
        chk("bp_hold", 32'(o_beat_cnt), 32'd2);
        i_dma2apb_full = 1'b0;
        repeat (3) step();
        chk("bp_resume", 32'(o_beat_cnt), 32'd5);
        i_ch_wvalid = '0; i_ch_req = '0;
        step();
        chk("drop_rel", 32'(o_ch_gnt), 32'h0);
        step();

        // Reset mid-grant on ch3.
        i_ch_req = 4'b1000;
        step();
        chk("mid_gnt3", 32'(o_ch_gnt), 32'h8);
        i_ch_wvalid = 4'b1000;
        repeat (5) step();
        i_ch_wvalid = '0;
        chk("mid_beat5", 32'(o_beat_cnt), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_gnt",  32'(o_ch_gnt),   32'h0);
        chk("mid_rst_beat", 32'(o_beat_cnt), 32'h0);
        chk("mid_rst_busy", 32'(o_busy),     32'h0);
        i_ch_req = 4'b1001;
        step();
        chk("mid_ptr0", 32'(o_ch_gnt), 32'h1);

        // enable low during GRANT: finish current, no new grant.
        enable = 1'b0;
        i_ch_done = 4'b0001;
        step();
        i_ch_done = '0;
        chk("en_rel", 32'(o_ch_gnt), 32'h0);
        step(); step(); step();
        chk("en_hold_gnt",  32'(o_ch_gnt), 32'h0);
        chk("en_hold_busy", 32'(o_busy),   32'h0);
        enable = 1'b1;
        step();
        chk("en_resume", 32'(o_ch_gnt), 32'h8);
        i_ch_done = 4'b1000;
        step();
        i_ch_done = '0; i_ch_req = '0;
        step(); step();
        chk("end_abort", 32'(o_ch_abort), 32'h0);
        chk("end_idle",  32'(o_busy),     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
